jtmikie_dwnld_conv: RTL and testbench

JTMIKIE_DWNLD_CONV -- requirements
Module: jtmikie_dwnld_conv

---
 rtl/jtmikie_dwnld_conv.sv | 134 +++++++++++++
 tb/tb_jtmikie_dwnld_conv.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/jtmikie_dwnld_conv.sv
// ROM download converter: classifies loader writes into CPU/SCR/OBJ/PROM regions,
// reformats scroll data and object addresses, and tracks byte count and checksum.
module jtmikie_dwnld_conv #(
  parameter logic [21:0] SCR_START  = 22'h0C000,
  parameter logic [21:0] OBJ_START  = 22'h10000,
  parameter logic [24:0] PROM_START = 25'h20000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        downloading,
  input  logic [24:0] ioctl_addr,
  input  logic [7:0]  ioctl_dout,
  input  logic        ioctl_wr,
  output logic [24:0] dwn_addr,
  output logic [7:0]  dwn_dout,
  output logic        dwn_wr,
  output logic [1:0]  region,
  output logic [24:0] byte_cnt,
  output logic [15:0] csum,
  output logic        done
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam logic [1:0] RG_CPU  = 2'd0;
  localparam logic [1:0] RG_SCR  = 2'd1;
  localparam logic [1:0] RG_OBJ  = 2'd2;
  localparam logic [1:0] RG_PROM = 2'd3;

  logic [1:0]  r_state;
  logic [24:0] r_dwn_addr;
  logic [7:0]  r_dwn_dout;
  logic        r_dwn_wr;
  logic [1:0]  r_region;
  logic [24:0] r_byte_cnt;
  logic [15:0] r_csum;

  logic        w_accept;
  logic        w_start;
  logic        w_is_scr;
  logic        w_is_obj;
  logic        w_is_prom;
  logic [1:0]  w_region;
  logic [24:0] w_obj_addr;
  logic [24:0] w_addr;
  logic [7:0]  w_data;

  // A write is taken during a download, including the very cycle it starts.
  assign w_accept  = ioctl_wr && ((r_state == ST_LOAD) || downloading);
  assign w_start   = (r_state == ST_IDLE) && downloading;

  assign w_is_scr  = (ioctl_addr[21:0] >= SCR_START) && (ioctl_addr[21:0] < OBJ_START);
  assign w_is_obj  = (ioctl_addr[21:0] >= OBJ_START) && (ioctl_addr < PROM_START);
  assign w_is_prom = (ioctl_addr >= PROM_START);

  // Object ROM bytes are shuffled so the sprite engine can fetch them linearly.
  always_comb begin
    w_obj_addr      = ioctl_addr;
    w_obj_addr[15]  = ioctl_addr[0];
    w_obj_addr[14]  = ioctl_addr[15];
    w_obj_addr[0]   = ~ioctl_addr[14];
    w_obj_addr[2:1] = ioctl_addr[5:4] + 2'd1;
    w_obj_addr[6:3] = {ioctl_addr[6], ioctl_addr[3:1]};
  end

  always_comb begin
    w_region = RG_CPU;
    w_addr   = ioctl_addr;
    w_data   = ioctl_dout;
    if (w_is_scr) begin
      w_region = RG_SCR;
      w_data   = {ioctl_dout[3:0], ioctl_dout[7:4]};
    end else if (w_is_obj) begin
      w_region = RG_OBJ;
      w_addr   = w_obj_addr;
    end else if (w_is_prom) begin
      w_region = RG_PROM;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: if (downloading) r_state <= ST_LOAD;
        ST_LOAD: if (!downloading) r_state <= ST_DONE;
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dwn_addr <= '0;
      r_dwn_dout <= '0;
      r_dwn_wr   <= 1'b0;
      r_region   <= RG_CPU;
    end else begin
      r_dwn_wr <= w_accept;
      if (w_accept) begin
        r_dwn_addr <= w_addr;
        r_dwn_dout <= w_data;
        r_region   <= w_region;
      end
    end
  end

  // A write landing on the start edge is counted after the clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_byte_cnt <= '0;
      r_csum     <= '0;
    end else if (w_start) begin
      r_byte_cnt <= w_accept ? 25'd1 : 25'd0;
      r_csum     <= w_accept ? {8'd0, ioctl_dout} : 16'd0;
    end else if (w_accept) begin
      if (r_byte_cnt != '1) r_byte_cnt <= r_byte_cnt + 25'd1;
      r_csum <= r_csum + {8'd0, ioctl_dout};
    end
  end

  assign dwn_addr = r_dwn_addr;
  assign dwn_dout = r_dwn_dout;
  assign dwn_wr   = r_dwn_wr;
  assign region   = r_region;
  assign byte_cnt = r_byte_cnt;
  assign csum     = r_csum;
  assign done     = (r_state == ST_DONE);

endmodule

// File: tb/tb_jtmikie_dwnld_conv.sv
// Directed bench for jtmikie_dwnld_conv with a scoreboard of expected converted writes
// and a reference model of region decode, address shuffle and counters.
module tb_jtmikie_dwnld_conv;

  typedef struct {
    logic [24:0] addr;
    logic [7:0]  data;
    logic [1:0]  region;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        downloading;
  logic [24:0] ioctl_addr;
  logic [7:0]  ioctl_dout;
  logic        ioctl_wr;
  logic [24:0] dwn_addr;
  logic [7:0]  dwn_dout;
  logic        dwn_wr;
  logic [1:0]  region;
  logic [24:0] byte_cnt;
  logic [15:0] csum;
  logic        done;

  int checks = 0;
  int errors = 0;
  int doneCount = 0;
  int doneSnap;
  exp_t sbQ[$];
  exp_t lastExp;
  logic [24:0] mCnt;
  logic [15:0] mSum;

  jtmikie_dwnld_conv dut (
    .clk(clk), .rst_n(rst_n), .downloading(downloading),
    .ioctl_addr(ioctl_addr), .ioctl_dout(ioctl_dout), .ioctl_wr(ioctl_wr),
    .dwn_addr(dwn_addr), .dwn_dout(dwn_dout), .dwn_wr(dwn_wr),
    .region(region), .byte_cnt(byte_cnt), .csum(csum), .done(done)
  );

  always #5 clk = ~clk;

  // Counts done as it stood during the previous cycle.
  always @(posedge clk) if (done === 1'b1) doneCount++;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t model(input logic [24:0] a, input logic [7:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.region = 2'd0;
    if (a[21:0] >= 22'h0C000 && a[21:0] < 22'h10000) begin
      e.region = 2'd1;
      e.data = {d[3:0], d[7:4]};
    end else if (a[21:0] >= 22'h10000 && a < 25'h20000) begin
      e.region = 2'd2;
      e.addr = {a[24:16], a[0], a[15], a[13:7], a[6], a[3:1], 2'(a[5:4] + 2'd1), ~a[14]};
    end else if (a >= 25'h20000) begin
      e.region = 2'd3;
    end
    return e;
  endfunction

  task automatic checkOutput(input logic expDone);
    if (sbQ.size() > 0) begin
      lastExp = sbQ.pop_front();
      checkVal("dwn_wr_pulse", 32'(dwn_wr), 32'd1);
    end else begin
      checkVal("dwn_wr_idle", 32'(dwn_wr), 32'd0);
    end
    checkVal("dwn_addr", 32'(dwn_addr), 32'(lastExp.addr));
    checkVal("dwn_dout", 32'(dwn_dout), 32'(lastExp.data));
    checkVal("region", 32'(region), 32'(lastExp.region));
    checkVal("byte_cnt", 32'(byte_cnt), 32'(mCnt));
    checkVal("csum", 32'(csum), 32'(mSum));
    checkVal("done", 32'(done), 32'(expDone));
  endtask

  task automatic applyStimulus(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr = 1'b1;
    sbQ.push_back(model(a, d));
    if (mCnt != '1) mCnt = mCnt + 25'd1;
    mSum = mSum + {8'd0, d};
    @(negedge clk);
    checkOutput(1'b0);
  endtask

  task automatic idleCycles(input int n);
    ioctl_wr = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checkOutput(1'b0);
    end
  endtask

  task automatic checkZeroOutputs();
    checkVal("rst_dwn_addr", 32'(dwn_addr), 32'd0);
    checkVal("rst_dwn_dout", 32'(dwn_dout), 32'd0);
    checkVal("rst_dwn_wr", 32'(dwn_wr), 32'd0);
    checkVal("rst_region", 32'(region), 32'd0);
    checkVal("rst_byte_cnt", 32'(byte_cnt), 32'd0);
    checkVal("rst_csum", 32'(csum), 32'd0);
    checkVal("rst_done", 32'(done), 32'd0);
  endtask

  // Ends a download: done for exactly one cycle, then a stray write must be ignored.
  task automatic endDownload();
    ioctl_wr = 1'b0;
    downloading = 1'b0;
    @(negedge clk);
    checkOutput(1'b1);
    @(negedge clk);
    checkOutput(1'b0);
    ioctl_addr = 25'h0C200;
    ioctl_dout = 8'h99;
    ioctl_wr = 1'b1;
    @(negedge clk);
    ioctl_wr = 1'b0;
    checkOutput(1'b0);
    idleCycles(2);
  endtask

  initial begin
    rst_n = 1'b0;
    downloading = 1'b0;
    ioctl_addr = '0;
    ioctl_dout = '0;
    ioctl_wr = 1'b0;
    mCnt = '0;
    mSum = '0;
    lastExp = '{addr: 25'd0, data: 8'd0, region: 2'd0};

    repeat (2) @(negedge clk);
    checkZeroOutputs();
    rst_n = 1'b1;
    idleCycles(2);

    // Download 1: first write shares the start edge, then SCR/OBJ conversions.
    downloading = 1'b1;
    mCnt = '0;
    mSum = '0;
    applyStimulus(25'h0C123, 8'hA5);
    checkVal("scr_addr_const", 32'(dwn_addr), 32'h0C123);
    checkVal("scr_data_const", 32'(dwn_dout), 32'h5A);
    checkVal("first_cnt_const", 32'(byte_cnt), 32'd1);
    idleCycles(2);
    applyStimulus(25'h10010, 8'h3C);
    checkVal("obj_addr_const", 32'(dwn_addr), 32'h10005);
    applyStimulus(25'h1C0F1, 8'h77);
    applyStimulus(25'h0FFFF, 8'h81);
    applyStimulus(25'h1FFFF, 8'h42);
    idleCycles(1);
    endDownload();
    checkVal("cnt_kept", 32'(byte_cnt), 32'd5);

    // Download 2: region 0 and PROM pass-through.
    downloading = 1'b1;
    mCnt = '0;
    mSum = '0;
    idleCycles(2);
    applyStimulus(25'h00100, 8'h12);
    applyStimulus(25'h20000, 8'h34);
    idleCycles(1);
    checkVal("d2_cnt_const", 32'(byte_cnt), 32'd2);
    checkVal("d2_csum_const", 32'(csum), 32'h0046);
    endDownload();

    // Download 3: 300 back-to-back 0xFF bytes exercising checksum wrap.
    downloading = 1'b1;
    mCnt = '0;
    mSum = '0;
    idleCycles(1);
    for (int i = 0; i < 300; i++) applyStimulus(25'(i * 3), 8'hFF);
    idleCycles(1);
    checkVal("d3_cnt_const", 32'(byte_cnt), 32'd300);
    doneSnap = doneCount;
    endDownload();
    checkVal("d3_done_once", 32'(doneCount - doneSnap), 32'd1);

    // Download 4: reset in the middle of a load.
    downloading = 1'b1;
    mCnt = '0;
    mSum = '0;
    idleCycles(1);
    applyStimulus(25'h0C010, 8'h1E);
    applyStimulus(25'h10020, 8'h2D);
    doneSnap = doneCount;
    ioctl_wr = 1'b0;
    rst_n = 1'b0;
    #1;
    checkZeroOutputs();
    repeat (3) begin
      @(negedge clk);
      checkZeroOutputs();
    end
    mCnt = '0;
    mSum = '0;
    lastExp = '{addr: 25'd0, data: 8'd0, region: 2'd0};
    rst_n = 1'b1;
    idleCycles(2);
    checkVal("rst_no_done", 32'(doneCount - doneSnap), 32'd0);
    applyStimulus(25'h20005, 8'h66);
    idleCycles(1);
    doneSnap = doneCount;
    endDownload();
    checkVal("post_rst_done", 32'(doneCount - doneSnap), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
